// File: rtl/conv_seq_controller.sv
// Convolution sequencer for a weight-stationary systolic array. It loads MAC_ROW weight words,
// streams OPIX ifmap words per pass, then drains the ofmap under sink backpressure.
// Every output comes from a flop, so each strobe appears one cycle after the decision behind it.
module conv_seq_controller #(
  parameter int unsigned MAC_ROW        = 16,
  parameter int unsigned MAC_COL        = 16,
  parameter int unsigned W_ADDR_BIT     = 11,
  parameter int unsigned IFMAP_ADDR_BIT = 12,
  parameter int unsigned OFMAP_ADDR_BIT = 10,
  parameter int unsigned CFG_BIT        = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_in,
  input  logic [CFG_BIT-1:0]        cfg_oct_in,
  input  logic [CFG_BIT-1:0]        cfg_ict_in,
  input  logic [CFG_BIT-1:0]        cfg_k_in,
  input  logic [CFG_BIT-1:0]        cfg_opix_in,
  input  logic                      ofmap_ready_in,
  output logic                      busy_out,
  output logic                      cfg_err_out,
  output logic                      w_prefetch_out,
  output logic [W_ADDR_BIT-1:0]     w_addr_out,
  output logic                      w_read_en_out,
  output logic                      ifmap_start_out,
  output logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_out,
  output logic                      ifmap_read_en_out,
  output logic                      mac_done_out,
  output logic [OFMAP_ADDR_BIT-1:0] ofmap_addr_out,
  output logic                      ofmap_write_en_out,
  output logic                      ofmap_write_done_out
);

  // Phase counter must hold both MAC_ROW-1 and OPIX-1.
  localparam int unsigned CntW   = (CFG_BIT > $clog2(MAC_ROW)) ? CFG_BIT : $clog2(MAC_ROW);
  localparam int unsigned WrCntW = OFMAP_ADDR_BIT + 1;

  if (MAC_ROW == 0 || MAC_COL == 0) begin : g_param_check
    $error("MAC_ROW and MAC_COL must be non-zero");
  end

  typedef enum logic [2:0] {StIdle, StWLoad, StStream, StWaitOut, StWrite} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [CFG_BIT-1:0]        cfg_oct_q, cfg_oct_d, cfg_ict_q, cfg_ict_d;
  logic [CFG_BIT-1:0]        cfg_k_q, cfg_k_d, cfg_opix_q, cfg_opix_d;
  logic [CFG_BIT-1:0]        t_oc_q, t_oc_d, t_ic_q, t_ic_d, t_k_q, t_k_d;
  logic [WrCntW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                      busy_q, busy_d, cfg_err_q, cfg_err_d;
  logic                      w_prefetch_q, w_prefetch_d, w_read_en_q, w_read_en_d;
  logic [W_ADDR_BIT-1:0]     w_addr_q, w_addr_d;
  logic                      ifmap_start_q, ifmap_start_d, ifmap_read_en_q, ifmap_read_en_d;
  logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_q, ifmap_addr_d;
  logic                      mac_done_q, mac_done_d;
  logic [OFMAP_ADDR_BIT-1:0] ofmap_addr_q, ofmap_addr_d;
  logic                      ofmap_write_en_q, ofmap_write_en_d;
  logic                      ofmap_write_done_q, ofmap_write_done_d;

  logic [63:0] w_need, if_need, of_need;
  logic        cfg_ok, k_last, ic_last, oc_last, all_written;

  // Config check runs on the live inputs, which are the values latched on the same edge.
  always_comb begin
    w_need  = 64'(cfg_oct_in) * 64'(cfg_ict_in) * 64'(cfg_k_in) * 64'(MAC_ROW);
    if_need = 64'(cfg_ict_in) * 64'(cfg_k_in) * 64'(cfg_opix_in);
    of_need = 64'(cfg_oct_in) * 64'(cfg_opix_in);
    cfg_ok  = (cfg_oct_in != '0) && (cfg_ict_in != '0) && (cfg_k_in != '0) &&
              (cfg_opix_in != '0) && (w_need <= (64'd1 << W_ADDR_BIT)) &&
              (if_need <= (64'd1 << IFMAP_ADDR_BIT)) && (of_need <= (64'd1 << OFMAP_ADDR_BIT));
    k_last      = (t_k_q == cfg_k_q - CFG_BIT'(1));
    ic_last     = (t_ic_q == cfg_ict_q - CFG_BIT'(1));
    oc_last     = (t_oc_q == cfg_oct_q - CFG_BIT'(1));
    all_written = (32'(wr_cnt_q) == 32'(cfg_oct_q) * 32'(cfg_opix_q));
  end

  // Next-state and next-output logic; strobes and pulses default low.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    cfg_oct_d          = cfg_oct_q;
    cfg_ict_d          = cfg_ict_q;
    cfg_k_d            = cfg_k_q;
    cfg_opix_d         = cfg_opix_q;
    t_oc_d             = t_oc_q;
    t_ic_d             = t_ic_q;
    t_k_d              = t_k_q;
    wr_cnt_d           = wr_cnt_q;
    busy_d             = busy_q;
    cfg_err_d          = 1'b0;
    w_prefetch_d       = 1'b0;
    w_read_en_d        = 1'b0;
    w_addr_d           = w_addr_q;
    ifmap_start_d      = 1'b0;
    ifmap_read_en_d    = 1'b0;
    ifmap_addr_d       = ifmap_addr_q;
    mac_done_d         = 1'b0;
    ofmap_addr_d       = ofmap_addr_q;
    ofmap_write_en_d   = 1'b0;
    ofmap_write_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // busy_q is still high in the write-done cycle, so a start there is ignored.
        if (start_in && !busy_q) begin
          cfg_oct_d  = cfg_oct_in;
          cfg_ict_d  = cfg_ict_in;
          cfg_k_d    = cfg_k_in;
          cfg_opix_d = cfg_opix_in;
          if (cfg_ok) begin
            state_d      = StWLoad;
            busy_d       = 1'b1;
            w_prefetch_d = 1'b1;
            w_read_en_d  = 1'b1;
            w_addr_d     = '0;
            cnt_d        = '0;
            t_oc_d       = '0;
            t_ic_d       = '0;
            t_k_d        = '0;
            wr_cnt_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StWLoad: begin
        if (cnt_q == CntW'(MAC_ROW - 1)) begin
          state_d         = StStream;
          cnt_d           = '0;
          ifmap_read_en_d = 1'b1;
          ifmap_start_d   = 1'b1;
          // ifmap addressing restarts with each output-channel tile.
          ifmap_addr_d    = (t_ic_q == '0 && t_k_q == '0) ? '0
                                                          : ifmap_addr_q + IFMAP_ADDR_BIT'(1);
        end else begin
          cnt_d        = cnt_q + CntW'(1);
          w_prefetch_d = 1'b1;
          w_read_en_d  = 1'b1;
          w_addr_d     = w_addr_q + W_ADDR_BIT'(1);
        end
      end
      StStream: begin
        if (cnt_q == CntW'(cfg_opix_q - CFG_BIT'(1))) begin
          cnt_d = '0;
          if (oc_last && ic_last && k_last) begin
            state_d    = StWaitOut;
            mac_done_d = 1'b1;
          end else begin
            state_d      = StWLoad;
            w_prefetch_d = 1'b1;
            w_read_en_d  = 1'b1;
            w_addr_d     = w_addr_q + W_ADDR_BIT'(1);
            if (k_last) begin
              t_k_d = '0;
              if (ic_last) begin
                t_ic_d = '0;
                t_oc_d = t_oc_q + CFG_BIT'(1);
              end else begin
                t_ic_d = t_ic_q + CFG_BIT'(1);
              end
            end else begin
              t_k_d = t_k_q + CFG_BIT'(1);
            end
          end
        end else begin
          cnt_d           = cnt_q + CntW'(1);
          ifmap_read_en_d = 1'b1;
          ifmap_addr_d    = ifmap_addr_q + IFMAP_ADDR_BIT'(1);
        end
      end
      StWaitOut, StWrite: begin
        if (all_written) begin
          state_d            = StIdle;
          ofmap_write_done_d = 1'b1;
        end else if (ofmap_ready_in) begin
          state_d          = StWrite;
          ofmap_write_en_d = 1'b1;
          ofmap_addr_d     = wr_cnt_q[OFMAP_ADDR_BIT-1:0];
          wr_cnt_d         = wr_cnt_q + WrCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      cfg_oct_q          <= '0;
      cfg_ict_q          <= '0;
      cfg_k_q            <= '0;
      cfg_opix_q         <= '0;
      t_oc_q             <= '0;
      t_ic_q             <= '0;
      t_k_q              <= '0;
      wr_cnt_q           <= '0;
      busy_q             <= 1'b0;
      cfg_err_q          <= 1'b0;
      w_prefetch_q       <= 1'b0;
      w_read_en_q        <= 1'b0;
      w_addr_q           <= '0;
      ifmap_start_q      <= 1'b0;
      ifmap_read_en_q    <= 1'b0;
      ifmap_addr_q       <= '0;
      mac_done_q         <= 1'b0;
      ofmap_addr_q       <= '0;
      ofmap_write_en_q   <= 1'b0;
      ofmap_write_done_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      cfg_oct_q          <= cfg_oct_d;
      cfg_ict_q          <= cfg_ict_d;
      cfg_k_q            <= cfg_k_d;
      cfg_opix_q         <= cfg_opix_d;
      t_oc_q             <= t_oc_d;
      t_ic_q             <= t_ic_d;
      t_k_q              <= t_k_d;
      wr_cnt_q           <= wr_cnt_d;
      busy_q             <= busy_d;
      cfg_err_q          <= cfg_err_d;
      w_prefetch_q       <= w_prefetch_d;
      w_read_en_q        <= w_read_en_d;
      w_addr_q           <= w_addr_d;
      ifmap_start_q      <= ifmap_start_d;
      ifmap_read_en_q    <= ifmap_read_en_d;
      ifmap_addr_q       <= ifmap_addr_d;
      mac_done_q         <= mac_done_d;
      ofmap_addr_q       <= ofmap_addr_d;
      ofmap_write_en_q   <= ofmap_write_en_d;
      ofmap_write_done_q <= ofmap_write_done_d;
    end
  end

  assign busy_out             = busy_q;
  assign cfg_err_out          = cfg_err_q;
  assign w_prefetch_out       = w_prefetch_q;
  assign w_addr_out           = w_addr_q;
  assign w_read_en_out        = w_read_en_q;
  assign ifmap_start_out      = ifmap_start_q;
  assign ifmap_addr_out       = ifmap_addr_q;
  assign ifmap_read_en_out    = ifmap_read_en_q;
  assign mac_done_out         = mac_done_q;
  assign ofmap_addr_out       = ofmap_addr_q;
  assign ofmap_write_en_out   = ofmap_write_en_q;
  assign ofmap_write_done_out = ofmap_write_done_q;

endmodule

// File: tb/tb_conv_seq_controller.sv
// Bench for conv_seq_controller: a config table drives whole operations, a negedge monitor
// checks every strobe against queued expectations, plus a mid-stream reset sequence.
module tb_conv_seq_controller;

  localparam int MacRow = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_in;
  logic [9:0]  cfg_oct_in, cfg_ict_in, cfg_k_in, cfg_opix_in;
  logic        ofmap_ready_in;
  logic        busy_out, cfg_err_out, w_prefetch_out, w_read_en_out;
  logic [10:0] w_addr_out;
  logic        ifmap_start_out, ifmap_read_en_out, mac_done_out;
  logic [11:0] ifmap_addr_out;
  logic [9:0]  ofmap_addr_out;
  logic        ofmap_write_en_out, ofmap_write_done_out;

  int checks = 0;
  int errors = 0;

  int unsigned w_q[$];
  int unsigned if_q[$];  // {addr, start} packed as addr*2+start
  int unsigned of_q[$];

  typedef struct {
    int oct;
    int ict;
    int k;
    int opix;
    bit err;
    bit gappy;
  } vec_t;

  vec_t vecs[11];

  conv_seq_controller #(
    .MAC_ROW(MacRow), .MAC_COL(16), .W_ADDR_BIT(11), .IFMAP_ADDR_BIT(12),
    .OFMAP_ADDR_BIT(10), .CFG_BIT(10)
  ) dut (
    .clk(clk), .rstn(rstn), .start_in(start_in),
    .cfg_oct_in(cfg_oct_in), .cfg_ict_in(cfg_ict_in), .cfg_k_in(cfg_k_in),
    .cfg_opix_in(cfg_opix_in), .ofmap_ready_in(ofmap_ready_in),
    .busy_out(busy_out), .cfg_err_out(cfg_err_out), .w_prefetch_out(w_prefetch_out),
    .w_addr_out(w_addr_out), .w_read_en_out(w_read_en_out),
    .ifmap_start_out(ifmap_start_out), .ifmap_addr_out(ifmap_addr_out),
    .ifmap_read_en_out(ifmap_read_en_out), .mac_done_out(mac_done_out),
    .ofmap_addr_out(ofmap_addr_out), .ofmap_write_en_out(ofmap_write_en_out),
    .ofmap_write_done_out(ofmap_write_done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  function automatic longint unsigned all_outs();
    return 64'({busy_out, cfg_err_out, w_prefetch_out, w_addr_out, w_read_en_out,
                ifmap_start_out, ifmap_addr_out, ifmap_read_en_out, mac_done_out,
                ofmap_addr_out, ofmap_write_en_out, ofmap_write_done_out});
  endfunction

  // Scoreboard monitor: every strobe pops one expected entry.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("reset_outputs", all_outs(), 0);
    end else begin
      if (w_read_en_out || w_prefetch_out) begin
        if (w_q.size() == 0) note_fail("w_extra_read");
        else begin
          chk("w_addr", w_addr_out, w_q.pop_front());
          chk("w_strobes", {w_prefetch_out, w_read_en_out}, 2'b11);
        end
      end
      if (ifmap_read_en_out || ifmap_start_out) begin
        if (if_q.size() == 0) note_fail("if_extra_read");
        else begin
          int unsigned e;
          e = if_q.pop_front();
          chk("if_addr", ifmap_addr_out, e >> 1);
          chk("if_start", {ifmap_read_en_out, ifmap_start_out}, {1'b1, e[0]});
        end
      end
      if (ofmap_write_en_out) begin
        if (of_q.size() == 0) note_fail("of_extra_write");
        else chk("of_addr", ofmap_addr_out, of_q.pop_front());
      end
    end
  end

  task automatic push_reads(input vec_t v);
    for (int i = 0; i < v.oct * v.ict * v.k * MacRow; i++) w_q.push_back(i);
    for (int oc = 0; oc < v.oct; oc++)
      for (int i = 0; i < v.ict * v.k * v.opix; i++)
        if_q.push_back(i * 2 + ((i % v.opix) == 0 ? 1 : 0));
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_oct_in  = 10'(v.oct);
    cfg_ict_in  = 10'(v.ict);
    cfg_k_in    = 10'(v.k);
    cfg_opix_in = 10'(v.opix);
  endtask

  task automatic recover();
    rstn = 1'b0;
    start_in = 1'b0;
    ofmap_ready_in = 1'b0;
    @(negedge clk);
    w_q.delete();
    if_q.delete();
    of_q.delete();
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One full operation, called at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int n, total, of_total, issued, idx;
    bit r;
    logic [3:0] pat;
    pat = 4'b1001;  // bit idx gives ready on cycle idx: 1,0,0,1
    total = v.oct * v.ict * v.k * (MacRow + v.opix);
    of_total = v.oct * v.opix;
    drive_cfg(v);
    start_in = 1'b1;
    if (!v.err) push_reads(v);
    @(negedge clk);
    chk("busy_after_start", busy_out, v.err ? 0 : 1);
    chk("cfg_err_pulse", cfg_err_out, v.err ? 1 : 0);
    if (v.err) begin
      start_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("err_stays_idle", {busy_out, cfg_err_out}, 0);
      end
      return;
    end
    // Scramble cfg and keep start high: both must be ignored while busy.
    cfg_oct_in = 10'd7; cfg_ict_in = 10'd7; cfg_k_in = 10'd7; cfg_opix_in = 10'd7;
    n = 0;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    start_in = 1'b0;
    while (!mac_done_out && n < total + 20) begin
      @(negedge clk);
      n++;
    end
    if (!mac_done_out) begin
      note_fail("mac_done_timeout");
      recover();
      return;
    end
    chk("compute_cycles", n, total);
    issued = 0;
    idx = 0;
    while (issued < of_total && idx < 4 * of_total + 10) begin
      r = v.gappy ? pat[idx % 4] : 1'b1;
      ofmap_ready_in = r;
      if (r) of_q.push_back(issued);
      @(negedge clk);
      idx++;
      chk("of_write_en", ofmap_write_en_out, r);
      chk("mac_done_single", mac_done_out, 0);
      chk("write_done_early", ofmap_write_done_out, 0);
      if (r) issued++;
      else if (issued > 0) chk("of_addr_hold", ofmap_addr_out, issued - 1);
    end
    if (issued < of_total) begin
      note_fail("write_timeout");
      recover();
      return;
    end
    @(negedge clk);
    ofmap_ready_in = 1'b0;
    chk("write_done_pulse", {ofmap_write_done_out, busy_out}, 2'b11);
    @(negedge clk);
    chk("back_to_idle", {ofmap_write_done_out, busy_out}, 2'b00);
    chk("w_reads_left", w_q.size(), 0);
    chk("if_reads_left", if_q.size(), 0);
    chk("of_writes_left", of_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int n;
    rstn = 1'b0;
    start_in = 1'b0;
    ofmap_ready_in = 1'b0;
    cfg_oct_in = '0; cfg_ict_in = '0; cfg_k_in = '0; cfg_opix_in = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 0);

    //          oct ict  k   opix err gappy
    vecs[0]  = '{1,  1,  1,   4,  0,  0};  // basic
    vecs[1]  = '{2,  3,  2,   5,  0,  1};  // nesting with ready gaps
    vecs[2]  = '{1,  1,  1,   1,  0,  0};  // smallest legal op
    vecs[3]  = '{1,  1,  0,   4,  1,  0};  // zero field
    vecs[4]  = '{3,  1,  1, 400,  1,  0};  // ofmap 1200 > 1024
    vecs[5]  = '{1,  1, 128,  1,  0,  0};  // weights exactly 2048
    vecs[6]  = '{1,  1, 129,  1,  1,  0};  // weights 2064 > 2048
    vecs[7]  = '{1,  1,  17, 241, 1,  0};  // ifmap 4097 > 4096
    vecs[8]  = '{4,  1,  1, 256,  0,  0};  // ofmap exactly 1024
    vecs[9]  = '{4,  2,  9, 196,  0,  1};  // full layer
    vecs[10] = '{0,  2,  2,   2,  1,  0};  // zero oct
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of STREAM, then a fresh operation.
    rv = '{1, 1, 1, 4, 0, 0};
    drive_cfg(rv);
    start_in = 1'b1;
    push_reads(rv);
    @(negedge clk);
    start_in = 1'b0;
    n = 0;
    while (if_q.size() > 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) note_fail("stream_timeout");
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    w_q.delete();
    if_q.delete();
    of_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_after_midreset", {busy_out, w_read_en_out, ifmap_read_en_out}, 0);
    run_vec(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_seq_controller.md
CONV_SEQ_CONTROLLER -- requirements
Module: conv_seq_controller

Interface
REQ-001 SHALL have parameter MAC_ROW, default 16: systolic rows, i.e. weight words loaded per pass.
REQ-002 SHALL have parameter MAC_COL, default 16: systolic columns (documentation only, no logic effect).
REQ-003 SHALL have parameters W_ADDR_BIT 11, IFMAP_ADDR_BIT 12 and OFMAP_ADDR_BIT 10: address widths of the weight, ifmap and ofmap RAMs.
REQ-004 SHALL have parameter CFG_BIT, default 10: width of each runtime config field.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rstn.
REQ-006 Ports:
 clk  in  1  clock
 rstn  in  1  async active-low reset
 start_in  in  1  start request, level-sampled
 cfg_oct_in  in  CFG_BIT  ofmap channel tiles (OC/MAC_COL)
 cfg_ict_in  in  CFG_BIT  ifmap channel tiles (IC/MAC_ROW)
 cfg_k_in  in  CFG_BIT  kernel elements (W*H)
 cfg_opix_in  in  CFG_BIT  ofmap pixels (W*H)
 ofmap_ready_in  in  1  ofmap sink ready, backpressure
 busy_out  out  1  operation in progress
 cfg_err_out  out  1  one-cycle pulse: config rejected
 w_prefetch_out  out  1  high during weight load
 w_addr_out  out  W_ADDR_BIT  weight RAM address
 w_read_en_out  out  1  weight read strobe
 ifmap_start_out  out  1  pulse on first ifmap read of a pass
 ifmap_addr_out  out  IFMAP_ADDR_BIT  ifmap RAM address
 ifmap_read_en_out  out  1  ifmap read strobe
 mac_done_out  out  1  one-cycle pulse: compute finished
 ofmap_addr_out  out  OFMAP_ADDR_BIT  ofmap RAM address
 ofmap_write_en_out  out  1  ofmap write strobe
 ofmap_write_done_out  out  1  one-cycle pulse: all ofmap written

Function
REQ-007 SHALL use FSM states IDLE, W_LOAD, STREAM, WAIT_OUT, WRITE; all outputs are registered.
REQ-008 In IDLE, start_in=1 SHALL latch all cfg fields; the sequencer ignores later cfg changes until return to IDLE.
REQ-009 SHALL reject the latched config if any field is 0, OCT*ICT*K*MAC_ROW > 2^W_ADDR_BIT, ICT*K*OPIX > 2^IFMAP_ADDR_BIT, or OCT*OPIX > 2^OFMAP_ADDR_BIT; on rejection, cfg_err_out pulses next cycle and the FSM stays in IDLE.
REQ-010 On a valid config, SHALL set busy_out=1 the next cycle and hold it until the cycle of ofmap_write_done_out inclusive.
REQ-011 SHALL nest passes (outer to inner) as t_oc<OCT, t_ic<ICT, k<K; each pass is one W_LOAD followed by one STREAM.
REQ-012 W_LOAD SHALL last exactly MAC_ROW cycles with w_prefetch_out=1 and w_read_en_out=1 each cycle.
REQ-013 w_addr_out SHALL start at 0 and increment by 1 per weight read across all passes, never resetting within an operation.
REQ-014 STREAM SHALL last exactly OPIX cycles with ifmap_read_en_out=1 each cycle; ifmap_start_out=1 in the first STREAM cycle only.
REQ-015 ifmap_addr_out SHALL be 0 at the start of each t_oc, increment by 1 per read, and reach ICT*K*OPIX-1 at the last read of that t_oc.
REQ-016 There SHALL be no bubble cycles between consecutive phases; total compute is OCT*ICT*K*(MAC_ROW+OPIX) cycles.
REQ-017 mac_done_out SHALL pulse the cycle after the last STREAM read; the FSM then enters WAIT_OUT.
REQ-018 In WAIT_OUT/WRITE, each cycle with ofmap_ready_in=1 SHALL issue one write: ofmap_write_en_out=1 with ofmap_addr_out=0,1,..,OCT*OPIX-1.
REQ-019 When ofmap_ready_in=0, SHALL hold ofmap_write_en_out=0 and keep ofmap_addr_out at its value.
REQ-020 ofmap_write_done_out SHALL pulse the cycle after the final write; the FSM then returns to IDLE.
REQ-021 start_in while busy_out=1 SHALL be ignored.
REQ-022 Read strobes SHALL be driven only in W_LOAD/STREAM and the write strobe only in WRITE; the RAM read latency is 1 cycle, external to this block.

Reset
REQ-023 rstn=0 SHALL immediately force IDLE, all outputs to 0 and all counters/latched config to 0, including mid-operation; the first start after release begins a fresh operation.

Verification
REQ-024 OCT=1, ICT=1, K=1, OPIX=4, MAC_ROW=16, ready=1 -> w_addr 0..15 over 16 cycles, then ifmap_addr 0..3 with ifmap_start on addr 0, mac_done next cycle, ofmap_addr 0..3, write_done pulse.
REQ-025 OCT=4, ICT=2, K=9, OPIX=196 -> 1152 weight reads, 14112 ifmap reads (addr wraps to 0 four times, max 3527), mac_done after exactly 15264 compute cycles, 784 writes.
REQ-026 cfg_k_in=0 or OCT=3/OPIX=400 (1200>1024) -> single cfg_err_out pulse, busy_out stays 0, no strobes.
REQ-027 ofmap_ready_in toggled 1,0,0,1 during WRITE -> writes only on the ready cycles, addr held across the gap, write count = OCT*OPIX exactly.
REQ-028 rstn pulsed low mid-STREAM, then start with OPIX=4 config -> outputs 0 during reset; new run restarts at w_addr 0 with no residual counts.
